// File: rtl/bnn_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// bnn_layer_sequencer_if
// Bundles the run handshake, buffer read bus and result signals of one
// binarized fully-connected layer sequencer.
//   master : the sequencer (drives read addresses, strobe, results, status)
//   slave  : layer top + activation/weight buffers (drive start, threshold,
//            returned read data)
// Signals: start, thresh, act_addr, w_addr, rd_en, act_data, w_data,
//          out_bits, busy, done.
// ---------------------------------------------------------------------------
interface bnn_layer_sequencer_if #(
  parameter int IN_BITS = 32,
  parameter int WORDS   = 4,
  parameter int NEURONS = 8,
  parameter int ACC_W   = 8
);
  localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WAW = (NEURONS * WORDS > 1) ? $clog2(NEURONS * WORDS) : 1;

  logic               start;
  logic [ACC_W-1:0]   thresh;
  logic [KW-1:0]      act_addr;
  logic [WAW-1:0]     w_addr;
  logic               rd_en;
  logic [IN_BITS-1:0] act_data;
  logic [IN_BITS-1:0] w_data;
  logic [NEURONS-1:0] out_bits;
  logic               busy;
  logic               done;

  modport master (
    input  start, thresh, act_data, w_data,
    output act_addr, w_addr, rd_en, out_bits, busy, done
  );

  modport slave (
    output start, thresh, act_data, w_data,
    input  act_addr, w_addr, rd_en, out_bits, busy, done
  );
endinterface

// File: rtl/bnn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// bnn_layer_sequencer
// Sequences one binarized fully-connected layer over a shared XNOR-popcount
// datapath: for every neuron n and input word k it reads activation word k
// and weight word n*WORDS+k, accumulates popcount(~(act ^ w)) and thresholds
// the neuron sum into out_bits[n].
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : bnn_layer_sequencer_if.master (start/thresh in, read bus out,
//          read data in, out_bits/busy/done out)
// ---------------------------------------------------------------------------
module bnn_layer_sequencer #(
  parameter int IN_BITS = 32,
  parameter int WORDS   = 4,
  parameter int NEURONS = 8,
  parameter int ACC_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  bnn_layer_sequencer_if.master   bus
);
  localparam int KW  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int NW  = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int WAW = (NEURONS * WORDS > 1) ? $clog2(NEURONS * WORDS) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_WAIT, S_DECIDE, S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [KW-1:0]      k_q, k_d;
  logic [NW-1:0]      n_q, n_d;
  logic [ACC_W-1:0]   acc_q;
  logic [ACC_W-1:0]   thr_q;
  logic [NEURONS-1:0] out_q;
  logic               busy_q;
  logic               done_q;
  logic               rd_vld_q;

  logic               accept;
  logic [IN_BITS-1:0] xnor_w;
  logic [ACC_W-1:0]   pop;

  assign accept = (state_q == S_IDLE) && bus.start;

  genvar gi;
  generate
    for (gi = 0; gi < IN_BITS; gi++) begin : g_xnor
      assign xnor_w[gi] = ~(bus.act_data[gi] ^ bus.w_data[gi]);
    end
  endgenerate

  always_comb begin
    pop = '0;
    for (int i = 0; i < IN_BITS; i++) begin
      pop = pop + ACC_W'(xnor_w[i]);
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          k_d     = '0;
          n_d     = '0;
        end
      end
      S_RUN: begin
        if (k_q == KW'(WORDS - 1)) begin
          state_d = S_WAIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      // Last word's data is returned during this cycle
      S_WAIT: state_d = S_DECIDE;
      S_DECIDE: begin
        k_d = '0;
        if (n_q == NW'(NEURONS - 1)) begin
          state_d = S_DONE;
        end else begin
          n_d     = n_q + NW'(1);
          state_d = S_RUN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      thr_q    <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_vld_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      n_q      <= n_d;
      // Buffers answer one cycle after the strobe
      rd_vld_q <= (state_q == S_RUN);
      busy_q   <= (state_d != S_IDLE);
      done_q   <= (state_d == S_DONE);
      if (accept) begin
        thr_q <= bus.thresh;
        out_q <= '0;
        acc_q <= '0;
      end else if (state_q == S_DECIDE) begin
        out_q[n_q] <= (acc_q >= thr_q);
        acc_q      <= '0;
      end else if (rd_vld_q) begin
        acc_q <= acc_q + pop;
      end
    end
  end

  assign bus.rd_en    = (state_q == S_RUN);
  assign bus.act_addr = k_q;
  assign bus.w_addr   = WAW'(n_q) * WAW'(WORDS) + WAW'(k_q);
  assign bus.out_bits = out_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
module tb_bnn_layer_sequencer;
  localparam int IN_BITS = 32;
  localparam int WORDS   = 4;
  localparam int NEURONS = 8;
  localparam int ACC_W   = 8;
  localparam int LAT     = NEURONS * (WORDS + 2);

  logic clk;
  logic rst;

  bnn_layer_sequencer_if #(
    .IN_BITS(IN_BITS), .WORDS(WORDS), .NEURONS(NEURONS), .ACC_W(ACC_W)
  ) bus ();

  bnn_layer_sequencer #(
    .IN_BITS(IN_BITS), .WORDS(WORDS), .NEURONS(NEURONS), .ACC_W(ACC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer contents
  logic [IN_BITS-1:0] act_mem [WORDS];
  logic [IN_BITS-1:0] w_mem   [NEURONS*WORDS];

  // One-cycle-latency buffer model
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.act_data <= act_mem[bus.act_addr];
      bus.w_data   <= w_mem[bus.w_addr];
    end
  end

  // Bus monitor: counts strobes and done pulses, logs read addresses
  int rden_cnt = 0;
  int done_cnt = 0;
  int wq[$];
  int aq[$];
  always @(posedge clk) begin
    if (bus.rd_en) begin
      rden_cnt <= rden_cnt + 1;
      wq.push_back(int'(bus.w_addr));
      aq.push_back(int'(bus.act_addr));
    end
    if (bus.done) done_cnt <= done_cnt + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: neuron n fires when the count of agreeing bits across all
  // of its words reaches the threshold.
  function automatic logic [NEURONS-1:0] model(input int th);
    logic [NEURONS-1:0] res;
    int sum;
    res = '0;
    for (int n = 0; n < NEURONS; n++) begin
      sum = 0;
      for (int k = 0; k < WORDS; k++)
        sum += $countones(~(act_mem[k] ^ w_mem[n*WORDS+k]));
      res[n] = (sum >= th);
    end
    return res;
  endfunction

  task automatic setup_equal();
    for (int k = 0; k < WORDS; k++) act_mem[k] = 32'hA5A5A5A5;
    for (int n = 0; n < NEURONS; n++)
      for (int k = 0; k < WORDS; k++) w_mem[n*WORDS+k] = act_mem[k];
  endtask

  task automatic setup_inverse();
    for (int k = 0; k < WORDS; k++) act_mem[k] = $urandom;
    for (int n = 0; n < NEURONS; n++)
      for (int k = 0; k < WORDS; k++) w_mem[n*WORDS+k] = ~act_mem[k];
  endtask

  // Neuron n agrees with the activations in exactly 16*n bit positions
  task automatic setup_graded();
    logic [IN_BITS-1:0] a;
    for (int k = 0; k < WORDS; k++) act_mem[k] = $urandom;
    for (int n = 0; n < NEURONS; n++) begin
      for (int k = 0; k < WORDS; k++) w_mem[n*WORDS+k] = ~act_mem[k];
      for (int b = 0; b < 16*n; b++) begin
        a = act_mem[b/IN_BITS];
        w_mem[n*WORDS + b/IN_BITS][b%IN_BITS] = a[b%IN_BITS];
      end
    end
  endtask

  task automatic setup_random();
    for (int k = 0; k < WORDS; k++) act_mem[k] = $urandom;
    for (int i = 0; i < NEURONS*WORDS; i++) w_mem[i] = $urandom;
  endtask

  // mode 0: plain run; 1: extra start pulses + thresh change; 2: reset at cycle 20
  task automatic do_run(input string name, input int th, input int mode,
                        output logic [NEURONS-1:0] result);
    logic [NEURONS-1:0] exp;
    int rd0, dn0, q0, lat, errs;
    bit got_done;
    exp = model(th);
    @(negedge clk);
    rd0 = rden_cnt; dn0 = done_cnt; q0 = wq.size();
    bus.start  = 1'b1;
    bus.thresh = ACC_W'(th);
    @(posedge clk);
    #1 bus.start = 1'b0;
    got_done = 0; lat = 0;
    for (int i = 1; i <= 4 * LAT && !got_done; i++) begin
      @(negedge clk);
      if (mode == 1 && i == 11) begin
        bus.start  = 1'b1;
        bus.thresh = ~ACC_W'(th);
      end
      if (mode == 1 && i == 12) bus.start = 1'b0;
      if (mode == 2 && i == 20) begin
        rst = 1'b1;
        break;
      end
      if (bus.done) begin
        got_done = 1;
        lat = i - 1;
      end
    end
    result = bus.out_bits;

    if (mode == 2) begin
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check({name, "_rst_busy"},  bus.busy, 0);
      check({name, "_rst_rden"},  bus.rd_en, 0);
      check({name, "_rst_out"},   bus.out_bits, 0);
      repeat (2 * LAT) @(negedge clk);
      check({name, "_rst_nodone"}, done_cnt - dn0, 0);
      check({name, "_rst_idle"},  bus.busy, 0);
      $display("run %s: reset at cycle 20, out_bits=0x%0h", name, bus.out_bits);
      return;
    end

    check({name, "_done_seen"}, got_done, 1);
    check({name, "_latency"}, lat, LAT);
    check({name, "_busy_at_done"}, bus.busy, 1);
    check({name, "_out_bits"}, bus.out_bits, exp);
    if (mode == 1) bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    @(negedge clk);
    check({name, "_done_pulse"}, bus.done, 0);
    check({name, "_busy_fall"}, bus.busy, 0);
    check({name, "_rden_total"}, rden_cnt - rd0, NEURONS * WORDS);
    errs = 0;
    for (int i = 0; i < NEURONS * WORDS; i++) begin
      if (q0 + i >= wq.size()) errs++;
      else if (wq[q0+i] != i || aq[q0+i] != i % WORDS) errs++;
    end
    check({name, "_addr_seq"}, errs, 0);
    if (mode == 1) begin
      repeat (2 * LAT) @(negedge clk);
      check({name, "_busy_idle"}, bus.busy, 0);
      check({name, "_out_hold"}, bus.out_bits, exp);
    end
    check({name, "_done_count"}, done_cnt - dn0, 1);
    $display("run %s: thresh=%0d out_bits=0x%0h expected=0x%0h latency=%0d",
             name, th, result, exp, lat);
  endtask

  logic [NEURONS-1:0] r;

  initial begin
    rst = 1'b1;
    bus.start  = 1'b0;
    bus.thresh = '0;
    for (int k = 0; k < WORDS; k++) act_mem[k] = '0;
    for (int i = 0; i < NEURONS*WORDS; i++) w_mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_rden", bus.rd_en, 0);
    check("reset_out", bus.out_bits, 0);
    check("reset_act_addr", bus.act_addr, 0);
    check("reset_w_addr", bus.w_addr, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    setup_equal();
    do_run("run1", 64, 0, r);
    check("run1_const", r, 8'hFF);

    setup_inverse();
    do_run("run2", 1, 0, r);
    check("run2_const", r, 8'h00);

    setup_graded();
    do_run("run3", 64, 0, r);
    check("run3_const", r, 8'hF0);

    setup_random();
    do_run("run4a", 0, 0, r);
    check("run4a_const", r, 8'hFF);
    do_run("run4b", 129, 0, r);
    check("run4b_const", r, 8'h00);

    setup_equal();
    do_run("run5", 64, 1, r);
    check("run5_const", r, 8'hFF);

    do_run("run6", 64, 2, r);
    do_run("run6_restart", 64, 0, r);
    check("run6_const", r, 8'hFF);

    for (int t = 0; t < 4; t++) begin
      setup_random();
      do_run($sformatf("rand%0d", t), int'($urandom_range(50, 80)), 0, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bnn_layer_sequencer.md
# bnn_layer_sequencer

Controller that sequences one binarized fully-connected layer of the BNN netlist over a shared XNOR-popcount datapath. On `start` it walks every output neuron and every input word, and drives read addresses into the activation buffer and the weight buffer. It accumulates the XNOR-popcount of each returned word pair, thresholds each neuron's sum into one output bit, and reports completion. It sits between the layer-level top and the weight/activation RAMs; its `out_bits` feed the next layer's activation buffer and the top-level check points.

## Interface
- `IN_BITS`, 32: bits per activation/weight word.
- `WORDS`, 4: words per neuron input vector (≥1).
- `NEURONS`, 8: output neurons per layer (≥1).
- `ACC_W`, 8: accumulator width, ≥ clog2(IN_BITS*WORDS+1).
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: run request; sampled only in IDLE.
- `thresh` in ACC_W: neuron threshold; sampled on the start-accept edge.
- `act_addr` out clog2(WORDS): activation word index.
- `w_addr` out clog2(NEURONS*WORDS): weight word index = n*WORDS + k.
- `rd_en` out 1: read strobe for both buffers.
- `act_data` in IN_BITS: activation word, valid 1 cycle after `rd_en`.
- `w_data` in IN_BITS: weight word, valid 1 cycle after `rd_en`.
- `out_bits` out NEURONS: bit n = 1 iff neuron n's popcount ≥ threshold.
- `busy` out 1: high from the accept edge until `done`, inclusive.
- `done` out 1: single-cycle completion pulse.

## Operation
- States: IDLE, RUN, WAIT, DECIDE, DONE. Counters: neuron `n` (0..NEURONS-1), word `k` (0..WORDS-1).
- IDLE: `busy`=0. If `start`: latch `thresh`, set n=0, k=0, acc=0, clear `out_bits`, go to RUN.
- RUN: `rd_en`=1, `act_addr`=k, `w_addr`=n*WORDS+k.
  - If k==WORDS-1: go to WAIT.
  - Otherwise: k++.
- WAIT: `rd_en`=0. The last word's data arrives. Go to DECIDE.
- DECIDE: `out_bits[n]` <= (acc ≥ latched thresh). Clear acc and k.
  - If n==NEURONS-1: go to DONE.
  - Otherwise: n++, go to RUN.
- DONE: `done`=1, `busy`=1. Go to IDLE on the next edge.
- Accumulate: `rd_vld` is `rd_en` delayed one cycle. When `rd_vld` is high, acc += popcount(~(act_data ^ w_data)).
  - Comparison is unsigned, ACC_W bits. The accumulator cannot overflow given the `ACC_W` rule.
- Outputs are registered, except that `rd_en` and the addresses are decoded directly from state and counter registers.
- `out_bits` holds its value after DONE until the next accepted `start` or `rst`.
- `start` outside IDLE is ignored. A `start` asserted during the DONE cycle is ignored as well.
- `thresh` changes after acceptance have no effect on the run.
- `thresh`=0 gives all ones. `thresh` > IN_BITS*WORDS gives all zeros.

## Timing
- Reset: state=IDLE, n=k=0, acc=0, `out_bits`=0, `busy`=0, `done`=0, `rd_en`=0, `act_addr`=0, `w_addr`=0.
- Reset mid-run aborts immediately. No `done` is produced and `out_bits` is cleared.
- Cost per neuron is WORDS+2 cycles: WORDS RUN, 1 WAIT, 1 DECIDE.
- Let E0 be the edge that accepts `start`.
  - The final `out_bits` value is written at edge E0 + NEURONS*(WORDS+2).
  - `done` is high during the cycle that follows that edge.
  - Defaults: E0+48.
- `busy` rises at E0 and falls one cycle after `done`. The block is back-to-back capable: the next `start` can be accepted at the edge after the DONE cycle.
- Read latency from the buffers is fixed at 1 cycle. A buffer with a different latency is not supported.

## Test plan
- Run 1: `act` = 0xA5A5A5A5 in all words, weights equal to `act` for all neurons, `thresh`=64, `start` pulse. Required: all 8 neurons score 128, `out_bits`=0xFF, `done` exactly 48 cycles after accept, `rd_en` high 32 cycles in total.
- Run 2: weights = ~act everywhere, `thresh`=1. Required: every sum is 0, `out_bits`=0x00.
- Run 3: neuron n's weights agree with `act` in exactly 16*n bits, `thresh`=64. Required: `out_bits`=0xF0. Also check that `w_addr` sequences 0..31 in order.
- Run 4: set `thresh`=0, then `thresh`=129, on arbitrary data. Required: `out_bits`=0xFF, then 0x00.
- Run 5: pulse `start` again at cycles 10 and 48 after accept, and change `thresh` mid-run. Required: exactly one `done`, result unaffected.
- Run 6: assert `rst` at cycle 20 of a run. Required: next cycle IDLE, `out_bits`=0, no `done`. A fresh `start` then reproduces Run 1's result.
